dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port, synchronous-read data memory between the MIPS CPU data port and a debug/loader port.
- The debug/loader port lets the bench or a host preload and dump data memory while the CPU runs.
- The CPU is stalled while its access is pending or another requester owns the memory; the debug requester uses a req/ack handshake.
- A starvation counter guarantees debug forward progress against a CPU that hits memory every cycle.

Parameters:
- AW, 32: byte address width of both requester ports.
- DW, 32: data width.
- STARVE_MAX, 4: consecutive lost arbitration cycles after which the debug port wins; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU data-memory access request; held stable while cpu_stall=1.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  AW  CPU byte address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  CPU read data; valid in the cycle a read completes.
- cpu_stall  out  1  freezes CPU PC/regfile update.
- dbg_req  in  1  debug request; held with its fields until dbg_ack.
- dbg_we  in  1  1=write, 0=read.
- dbg_addr  in  AW  debug byte address.
- dbg_wdata  in  DW  debug write data.
- dbg_ack  out  1  one-cycle completion pulse, registered.
- dbg_rdata  out  DW  registered debug read data; valid with dbg_ack and held until the next debug read.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW-2  word address (addr[AW-1:2]).
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; 1-cycle latency after mem_en with mem_we=0.

Behaviour:
- FSM states: IDLE, RD_CPU, RD_DBG.
- Reset (rst=0, async): state=IDLE, starve_cnt=0, dbg_ack=0, dbg_rdata=0. Combinational outputs are forced to 0 while rst=0: mem_en, mem_we, cpu_stall. Reset mid-read abandons the access; no ack is ever issued for it.
- Debug eligibility: dbg_req=1 and dbg_ack=0. The requester drops dbg_req in the cycle it sees ack.
- Winner, evaluated in IDLE only:
  - Debug wins if it is eligible and (cpu_req=0 or starve_cnt>=STARVE_MAX).
  - Otherwise the CPU wins if cpu_req=1.
  - Otherwise no access is issued.
- Issue cycle (IDLE with a winner): mem_en=1; mem_we, mem_addr and mem_wdata are driven combinationally from the winner.
- CPU write: completes in the issue cycle with cpu_stall=0. FSM stays in IDLE, so one write per cycle is possible.
- CPU read: cpu_stall=1 in the issue cycle, then go to RD_CPU.
- RD_CPU: cpu_rdata=mem_rdata, cpu_stall=0, mem_en=0, then return to IDLE. Each CPU read costs exactly 2 cycles.
- Debug write: written in the issue cycle. dbg_ack=1 the next cycle. FSM stays in IDLE.
- Debug read: go to RD_DBG. In RD_DBG, capture dbg_rdata<=mem_rdata and set dbg_ack=1 for the next cycle, then return to IDLE.
- cpu_stall = cpu_req and not (CPU write winning in IDLE) and not (state==RD_CPU).
  - Consequence: the CPU is stalled in RD_DBG and whenever debug wins.
- cpu_rdata is 0 outside RD_CPU.
- starve_cnt:
  - Cleared when debug wins.
  - Incremented (saturating at 15) on each IDLE cycle where debug is eligible but the CPU wins.
  - Unchanged otherwise.
- Ack/request overlap: in the ack cycle a still-high dbg_req is ignored, which prevents a double issue. A CPU request in that cycle is served normally.
- Addresses are word aligned; addr[1:0] is ignored and no fault is raised.

Test Plan:
- Reset: hold rst=0 with all requests high → mem_en=0, cpu_stall=0, dbg_ack=0, dbg_rdata=0.
- Reset mid-read: assert rst=0 during RD_DBG → FSM returns to IDLE, and dbg_ack never pulses for that read.
- CPU access:
  - CPU write addr 0x50, data 7 → mem_en=1, mem_we=1, mem_addr=0x14 in the same cycle, cpu_stall=0.
  - Then a CPU read of 0x50 → stall=1 for 1 cycle, cpu_rdata=7 in the next cycle.
- Debug access:
  - dbg write 0x54, data 0x1234 with CPU idle → dbg_ack pulses 1 cycle later.
  - Then a dbg read of 0x54 → dbg_ack 2 cycles after issue, dbg_rdata=0x1234 held after ack.
- Starvation: CPU reads back-to-back with dbg_req high and STARVE_MAX=4 → debug issues at the 5th IDLE arbitration, the CPU stalls through it, and starve_cnt returns to 0.
- Simultaneous requests with starve_cnt=0 → the CPU is served first. No duplicate debug access occurs while dbg_req stays high through the ack cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port, synchronous-read data memory between
// the CPU data port and a debug/loader port.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata    CPU access; held stable while cpu_stall=1
//   cpu_rdata, cpu_stall     CPU read data (valid in RD_CPU), stall
//   dbg_req/we/addr/wdata    debug access; held until dbg_ack
//   dbg_ack, dbg_rdata       registered completion pulse and read data
//   mem_en/we/addr/wdata     memory command (word address)
//   mem_rdata                memory read data, 1-cycle latency
//
// Arbitration happens only in IDLE. The CPU has priority unless the debug
// port has lost STARVE_MAX consecutive eligible arbitrations.
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-3:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD_CPU, RD_DBG} state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e        state_q, state_d;
  logic [3:0]    starve_q, starve_d;
  logic          dbg_ack_q, dbg_ack_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;

  logic idle, dbg_elig, dbg_win, cpu_win;

  // Byte-lane bits are ignored; misaligned addresses are silently truncated.
  logic unused_lsbs;
  assign unused_lsbs = ^{cpu_addr[1:0], dbg_addr[1:0]};

  always_comb begin
    idle     = (state_q == IDLE);
    // A request still high in its ack cycle is the old one, not a new one.
    dbg_elig = dbg_req & ~dbg_ack_q;
    dbg_win  = idle & dbg_elig & (~cpu_req | (starve_q >= STARVE_LIM));
    cpu_win  = idle & cpu_req & ~dbg_win;

    state_d     = state_q;
    starve_d    = starve_q;
    dbg_ack_d   = 1'b0;
    dbg_rdata_d = dbg_rdata_q;

    mem_en    = dbg_win | cpu_win;
    mem_we    = 1'b0;
    mem_addr  = cpu_addr[AW-1:2];
    mem_wdata = cpu_wdata;
    if (dbg_win) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr[AW-1:2];
      mem_wdata = dbg_wdata;
    end else if (cpu_win) begin
      mem_we = cpu_we;
    end

    // CPU writes retire in the issue cycle; reads retire in RD_CPU.
    cpu_stall = cpu_req & ~(cpu_win & cpu_we) & (state_q != RD_CPU);
    cpu_rdata = (state_q == RD_CPU) ? mem_rdata : '0;

    unique case (state_q)
      IDLE: begin
        if (dbg_win) begin
          starve_d = '0;
          if (dbg_we) dbg_ack_d = 1'b1;
          else        state_d   = RD_DBG;
        end else if (cpu_win) begin
          if (dbg_elig && starve_q != 4'hF) starve_d = starve_q + 4'd1;
          if (!cpu_we) state_d = RD_CPU;
        end
      end
      RD_CPU: state_d = IDLE;
      RD_DBG: begin
        dbg_ack_d   = 1'b1;
        dbg_rdata_d = mem_rdata;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!rst) begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      cpu_stall = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      dbg_ack_q   <= dbg_ack_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign dbg_ack   = dbg_ack_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata;
  logic          cpu_stall, dbg_ack, mem_en, mem_we;
  logic [AW-3:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem [256] = '{default: '0};

  int errors = 0;
  int checks = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous-read memory.
  always @(posedge clk) begin
    if (mem_en && mem_we)  mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model state: shadow of the memory words touched by random traffic.
  logic [DW-1:0] sh [8];
  int            dpos [$];
  int            arb, acks, n_dbg, lat, idx, w, isdbg;
  logic [DW-1:0] data;
  logic [AW-1:0] addr;

  initial begin
    for (int i = 0; i < 8; i++) sh[i] = '0;
    // Reset with every request asserted.
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h50; cpu_wdata = 32'h7;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h54; dbg_wdata = 32'h0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_men",   64'(mem_en),    64'd0);
    chk("rst_mwe",   64'(mem_we),    64'd0);
    chk("rst_stall", 64'(cpu_stall), 64'd0);
    chk("rst_ack",   64'(dbg_ack),   64'd0);
    chk("rst_drd",   64'(dbg_rdata), 64'd0);
    @(negedge clk);
    rst = 1'b1; cpu_req = 1'b0; dbg_req = 1'b0;

    // CPU write 0x50 <- 7, then read it back.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h50; cpu_wdata = 32'h7; #1;
    chk("cw_en",    64'(mem_en),    64'd1);
    chk("cw_we",    64'(mem_we),    64'd1);
    chk("cw_addr",  64'(mem_addr),  64'h14);
    chk("cw_data",  64'(mem_wdata), 64'h7);
    chk("cw_stall", 64'(cpu_stall), 64'd0);
    @(negedge clk);
    cpu_we = 1'b0; #1;
    chk("cr_en",    64'(mem_en),    64'd1);
    chk("cr_we",    64'(mem_we),    64'd0);
    chk("cr_stall", 64'(cpu_stall), 64'd1);
    @(negedge clk); #1;
    chk("cr_stall2", 64'(cpu_stall), 64'd0);
    chk("cr_data",   64'(cpu_rdata), 64'h7);
    chk("cr_en2",    64'(mem_en),    64'd0);
    @(negedge clk);
    cpu_req = 1'b0; #1;
    chk("cr_idle_rd", 64'(cpu_rdata), 64'd0);

    // Debug write 0x54 <- 0x1234, request held through the ack cycle.
    @(negedge clk);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h54; dbg_wdata = 32'h1234; #1;
    chk("dw_en",   64'(mem_en),   64'd1);
    chk("dw_we",   64'(mem_we),   64'd1);
    chk("dw_addr", 64'(mem_addr), 64'h15);
    chk("dw_ack0", 64'(dbg_ack),  64'd0);
    @(negedge clk); #1;
    chk("dw_ack1",  64'(dbg_ack), 64'd1);
    chk("dw_noreq", 64'(mem_en),  64'd0);
    @(negedge clk);
    dbg_req = 1'b0; #1;
    chk("dw_ack2", 64'(dbg_ack), 64'd0);

    // Debug read of 0x54: ack two cycles after issue, data held afterwards.
    @(negedge clk);
    dbg_req = 1'b1; dbg_we = 1'b0; #1;
    chk("dr_en",   64'(mem_en),  64'd1);
    chk("dr_we",   64'(mem_we),  64'd0);
    @(negedge clk); #1;
    chk("dr_ack0", 64'(dbg_ack), 64'd0);
    chk("dr_en2",  64'(mem_en),  64'd0);
    @(negedge clk); #1;
    chk("dr_ack1", 64'(dbg_ack),   64'd1);
    chk("dr_data", 64'(dbg_rdata), 64'h1234);
    @(negedge clk);
    dbg_req = 1'b0; #1;
    chk("dr_ack2", 64'(dbg_ack),   64'd0);
    chk("dr_hold", 64'(dbg_rdata), 64'h1234);

    // Simultaneous reads with a fresh starvation count: CPU first, one debug issue.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h50;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h54; #1;
    chk("sim_addr",  64'(mem_addr),  64'h14);
    chk("sim_stall", 64'(cpu_stall), 64'd1);
    @(negedge clk); #1;
    chk("sim_crd",    64'(cpu_rdata), 64'h7);
    chk("sim_stall2", 64'(cpu_stall), 64'd0);
    @(negedge clk);
    cpu_req = 1'b0;
    n_dbg = 0; acks = 0;
    for (int c = 0; c < 6 && acks == 0; c++) begin
      #1;
      if (mem_en && mem_addr == 30'h15) n_dbg++;
      if (dbg_ack) begin
        acks++;
        chk("sim_noreissue", 64'(mem_en), 64'd0);
      end else begin
        @(negedge clk);
      end
    end
    chk("sim_acked", 64'(acks), 64'd1);
    @(negedge clk);
    dbg_req = 1'b0; #1;
    chk("sim_ndbg", 64'(n_dbg),     64'd1);
    chk("sim_drd",  64'(dbg_rdata), 64'h1234);

    // Starvation: CPU reads every cycle, debug read held continuously.
    // Each ack cycle makes debug ineligible, so after the first win the
    // debug port loses the ack-cycle slot plus SM eligible slots.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h50;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h54;
    arb = 0; acks = 0; dpos.delete();
    for (int c = 0; c < 60 && acks < 3; c++) begin
      #1;
      if (mem_en) begin
        arb++;
        if (mem_addr == 30'h15) begin
          dpos.push_back(arb);
          chk("stv_stall", 64'(cpu_stall), 64'd1);
        end
      end
      if (dbg_ack) begin
        acks++;
        chk("stv_drd", 64'(dbg_rdata), 64'h1234);
      end
      @(negedge clk);
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    chk("stv_acks", 64'(acks), 64'd3);
    chk("stv_n",    64'(dpos.size()), 64'd3);
    for (int k = 0; k < dpos.size(); k++)
      chk($sformatf("stv_pos%0d", k), 64'(dpos[k]), 64'((SM + 1) + k * (SM + 2)));
    @(negedge clk); @(negedge clk);

    // Reset in the middle of a debug read: no ack, FSM back in IDLE.
    @(negedge clk);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h54; #1;
    chk("mr_en", 64'(mem_en), 64'd1);
    @(negedge clk);
    rst = 1'b0; #1;
    chk("mr_en0",  64'(mem_en),    64'd0);
    chk("mr_ack0", 64'(dbg_ack),   64'd0);
    chk("mr_drd",  64'(dbg_rdata), 64'd0);
    @(negedge clk);
    rst = 1'b1; dbg_req = 1'b0; #1;
    chk("mr_ack1", 64'(dbg_ack), 64'd0);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h58; cpu_wdata = 32'h9; #1;
    chk("mr_idle", 64'(mem_en),  64'd1);
    chk("mr_ack2", 64'(dbg_ack), 64'd0);
    @(negedge clk);
    cpu_req = 1'b0; #1;
    chk("mr_ack3", 64'(dbg_ack), 64'd0);

    // Random single-requester traffic against the shadow memory model.
    for (int t = 0; t < 60; t++) begin
      idx   = int'($urandom_range(0, 7));
      w     = int'($urandom_range(0, 1));
      isdbg = int'($urandom_range(0, 1));
      data  = $urandom;
      addr  = 32'h80 + 32'(idx * 4) + 32'($urandom_range(0, 3));
      @(negedge clk);
      if (isdbg == 0) begin
        cpu_req = 1'b1; cpu_we = w[0]; cpu_addr = addr; cpu_wdata = data; #1;
        chk("r_cen",   64'(mem_en),   64'd1);
        chk("r_caddr", 64'(mem_addr), 64'(32'h20 + idx));
        if (w != 0) begin
          chk("r_cstall_w", 64'(cpu_stall), 64'd0);
          sh[idx] = data;
          @(negedge clk);
          cpu_req = 1'b0;
        end else begin
          chk("r_cstall_r", 64'(cpu_stall), 64'd1);
          @(negedge clk); #1;
          chk("r_cstall_d", 64'(cpu_stall), 64'd0);
          chk("r_crd",      64'(cpu_rdata), 64'(sh[idx]));
          cpu_req = 1'b0;
        end
      end else begin
        dbg_req = 1'b1; dbg_we = w[0]; dbg_addr = addr; dbg_wdata = data; #1;
        chk("r_den",   64'(mem_en),   64'd1);
        chk("r_daddr", 64'(mem_addr), 64'(32'h20 + idx));
        lat = -1;
        for (int k = 1; k <= 4 && lat < 0; k++) begin
          @(negedge clk); #1;
          if (dbg_ack) lat = k;
        end
        dbg_req = 1'b0;
        chk("r_dlat", 64'(lat), (w != 0) ? 64'd1 : 64'd2);
        if (w != 0) sh[idx] = data;
        else        chk("r_drd", 64'(dbg_rdata), 64'(sh[idx]));
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
